cbus_arbiter: RTL and testbench

- Sits directly downstream of the instruction cache and data cache, between their cache-bus request ports and the single memory-side CBus.
- Arbitrates NUM_MASTERS cbus_req_t masters onto one cbus_req_t output.
- Grants one master per transaction, round-robin.
- Routes the memory response back to the granted master only, and holds the grant until the burst's final beat completes.

---
 rtl/cbus_arbiter.sv | 135 +++++++++++++
 tb/tb_cbus_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: round-robin arbiter from N cache CBus masters onto one
// memory-side CBus; holds each grant until the final beat of its burst.
// Ports: clk, reset (sync, active-high), ireqs[N] in, iresps[N] out,
//        oreq out (memory request), oresp in (ready/last/data).
// Optional: define CBUS_ARB_FIXED_PRIO_EN for fixed lowest-index-wins
//           priority instead of round-robin.

package cbus_pkg;
   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [3:0]  strobe;
      logic [31:0] data;
      logic [7:0]  len;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] data;
   } cbus_resp_t;
endpackage

module cbus_arbiter
   import cbus_pkg::*;
#(
   parameter  int NUM_MASTERS = 2,
   localparam int SEL_W       = $clog2(NUM_MASTERS)
) (
   input  logic       clk,
   input  logic       reset,
   input  cbus_req_t  ireqs  [NUM_MASTERS],
   output cbus_resp_t iresps [NUM_MASTERS],
   output cbus_req_t  oreq,
   input  cbus_resp_t oresp
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [SEL_W-1:0] pick;
   logic             found;

`ifdef CBUS_ARB_FIXED_PRIO_EN
   // Lowest valid index wins; scanning downward lets the
   // last hit be the smallest index.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         if (ireqs[i].valid) begin
            found = 1'b1;
            pick  = SEL_W'(i);
         end
      end
   end
`else
   logic [SEL_W-1:0] last_grant_q, last_grant_d;
   logic [SEL_W-1:0] rr_idx;

   // Scan starts just after the previous winner so the most
   // recent owner gets the lowest priority.
   always_comb begin
      found  = 1'b0;
      pick   = '0;
      rr_idx = '0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         rr_idx = SEL_W'((int'(last_grant_q) + k) % NUM_MASTERS);
         if (!found && ireqs[rr_idx].valid) begin
            found = 1'b1;
            pick  = rr_idx;
         end
      end
   end
`endif

   // Data path: only the granted master is connected while BUSY.
   always_comb begin
      oreq = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         iresps[i] = '0;
      end
      if (state_q == BUSY) begin
         oreq          = ireqs[sel_q];
         iresps[sel_q] = oresp;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
`ifndef CBUS_ARB_FIXED_PRIO_EN
      last_grant_d = last_grant_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (found) begin
               sel_d   = pick;
               state_d = BUSY;
            end
         end
         BUSY: begin
            // Grant is locked until the final beat completes.
            if (oresp.ready && oresp.last) begin
`ifndef CBUS_ARB_FIXED_PRIO_EN
               last_grant_d = sel_q;
`endif
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         sel_q   <= '0;
`ifndef CBUS_ARB_FIXED_PRIO_EN
         last_grant_q <= SEL_W'(NUM_MASTERS - 1);
`endif
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
`ifndef CBUS_ARB_FIXED_PRIO_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

endmodule

// File: tb/tb_cbus_arbiter.sv
// tb_cbus_arbiter: directed bench for cbus_arbiter with two masters.
// Drives and samples on the falling clock edge.

module tb_cbus_arbiter;
   import cbus_pkg::*;

   localparam int N = 2;
`ifdef CBUS_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   cbus_req_t  ireqs  [N];
   cbus_resp_t iresps [N];
   cbus_req_t  oreq;
   cbus_resp_t oresp;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   cbus_arbiter #(.NUM_MASTERS(N)) dut (
      .clk    (clk),
      .reset  (reset),
      .ireqs  (ireqs),
      .iresps (iresps),
      .oreq   (oreq),
      .oresp  (oresp)
   );

   function automatic logic [31:0] addr_of(int m);
      return 32'(m + 1) << 28;
   endfunction

   function automatic logic [31:0] beat_data(int m, int b);
      return 32'hA000_0000 + 32'(m * 256 + b);
   endfunction

   task automatic check(string tag, logic [63:0] got,
                        logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic set_req(int m, bit v, logic [7:0] len);
      ireqs[m]       = '0;
      ireqs[m].valid = v;
      ireqs[m].addr  = addr_of(m);
      ireqs[m].len   = len;
      ireqs[m].data  = 32'h5500 + 32'(m);
   endtask

   // Entered on the falling edge of the first BUSY cycle for
   // master m; leaves at +1 into the dead IDLE cycle.
   task automatic serve(int m, int beats, int stall_at,
                        int stall_len, int raise_at);
      int o;
      o = 1 - m;
      for (int b = 0; b < beats; b++) begin
         if (b == raise_at) set_req(0, 1'b1, 8'd0);
         if (b == stall_at) begin
            for (int s = 0; s < stall_len; s++) begin
               oresp = '0;
               #1;
               check("stall_v", oreq.valid, 1);
               check("stall_addr", oreq.addr, addr_of(m));
               check("stall_rdy", iresps[m].ready, 0);
               check("stall_oth", iresps[o] == '0, 1);
               @(negedge clk);
            end
         end
         oresp.ready = 1'b1;
         oresp.last  = (b == beats - 1);
         oresp.data  = beat_data(m, b);
         #1;
         check("beat_v", oreq.valid, 1);
         check("beat_addr", oreq.addr, addr_of(m));
         check("rsp_rdy", iresps[m].ready, 1);
         check("rsp_last", iresps[m].last, b == beats - 1);
         check("rsp_data", iresps[m].data, beat_data(m, b));
         check("rsp_oth", iresps[o] == '0, 1);
         @(negedge clk);
      end
      oresp = '0;
      #1;
      check("dead_v", oreq.valid, 0);
   endtask

   int m5;

   initial begin
      reset = 1'b1;
      oresp = '0;
      set_req(0, 1'b0, 8'd0);
      set_req(1, 1'b0, 8'd0);
      repeat (2) @(negedge clk);
      #1;
      check("rst_oreq", oreq == '0, 1);
      check("rst_resp0", iresps[0] == '0, 1);
      check("rst_resp1", iresps[1] == '0, 1);

      // Single-beat read from master 0
      @(negedge clk);
      reset = 1'b0;
      set_req(0, 1'b1, 8'd0);
      ireqs[0].addr = 32'h8000_0000;
      #1;
      check("t1_lat0", oreq.valid, 0);
      @(negedge clk);
      #1;
      check("t1_v", oreq.valid, 1);
      check("t1_addr", oreq.addr, 32'h8000_0000);
      oresp.ready = 1'b1;
      oresp.last  = 1'b1;
      oresp.data  = 32'hDEAD_BEEF;
      #1;
      check("t1_data", iresps[0].data, 32'hDEAD_BEEF);
      check("t1_rdy", iresps[0].ready, 1);
      check("t1_oth", iresps[1] == '0, 1);
      @(negedge clk);
      set_req(0, 1'b0, 8'd0);
      oresp = '0;
      #1;
      check("t1_idle", oreq.valid, 0);

      // Both masters contending from reset, 4-beat bursts
      @(negedge clk);
      reset = 1'b1;
      set_req(0, 1'b1, 8'd3);
      set_req(1, 1'b1, 8'd3);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("t2_idle", oreq.valid, 0);
      @(negedge clk);
      for (int t = 0; t < 4; t++) begin
         serve(FIXED ? 0 : t % 2, 4, -1, 0, -1);
         if (t < 3) @(negedge clk);
      end

      // Master 1 8-beat burst, master 0 joins at beat 2
      set_req(0, 1'b0, 8'd0);
      set_req(1, 1'b1, 8'd7);
      @(negedge clk);
      serve(1, 8, -1, 0, 2);
      set_req(1, 1'b1, 8'd3);
      @(negedge clk);
      serve(0, 1, -1, 0, -1);

      // Memory stall mid-burst with the other master waiting
      set_req(0, 1'b1, 8'd3);
      m5 = FIXED ? 0 : 1;
      @(negedge clk);
      serve(m5, 4, 2, 5, -1);

      // Reset at beat 2 of a burst from master 1
      set_req(0, 1'b0, 8'd0);
      set_req(1, 1'b1, 8'd3);
      @(negedge clk);
      for (int b = 0; b < 2; b++) begin
         oresp.ready = 1'b1;
         oresp.last  = 1'b0;
         #1;
         check("t4_addr", oreq.addr, addr_of(1));
         @(negedge clk);
      end
      reset = 1'b1;
      set_req(0, 1'b1, 8'd0);
      @(negedge clk);
      reset = 1'b0;
      oresp = '0;
      #1;
      check("t4_v", oreq.valid, 0);
      check("t4_r0", iresps[0] == '0, 1);
      check("t4_r1", iresps[1] == '0, 1);
      @(negedge clk);
      #1;
      check("t4_gv", oreq.valid, 1);
      check("t4_gaddr", oreq.addr, addr_of(0));
      oresp.ready = 1'b1;
      oresp.last  = 1'b1;
      @(negedge clk);
      set_req(0, 1'b0, 8'd0);
      set_req(1, 1'b0, 8'd0);
      oresp = '0;
      #1;
      check("t4_end", oreq.valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
